// File: rtl/obi_interconnect_slave_port_if.sv
// Bus bundle between the master-select/master side and one slave port stage.
// The slave modport is the port stage itself; the master modport is its environment.
interface obi_interconnect_slave_port_if #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
);
  logic [MASTER_BITS-1:0]        master_sel_int_i;
  logic [MASTERS-1:0]            master_sel_vec_i;
  logic                          granted_master_i;
  logic [MASTERS-1:0][31:0]      master_addr_i;
  logic [MASTERS-1:0]            master_we_i;
  logic [MASTERS-1:0][3:0]       master_be_i;
  logic [MASTERS-1:0][31:0]      master_wdata_i;
  logic [MASTERS-1:0]            master_gnt_o;
  logic [MASTERS-1:0]            master_rvalid_o;
  logic [MASTERS-1:0][31:0]      master_rdata_o;
  logic                          slave_req_o;
  logic                          slave_gnt_i;
  logic [31:0]                   slave_addr_o;
  logic                          slave_we_o;
  logic [3:0]                    slave_be_o;
  logic [31:0]                   slave_wdata_o;
  logic                          slave_rvalid_i;
  logic [31:0]                   slave_rdata_i;
  logic                          rsp_err_o;

  modport slave (
    input  master_sel_int_i, master_sel_vec_i, granted_master_i,
    input  master_addr_i, master_we_i, master_be_i, master_wdata_i,
    output master_gnt_o, master_rvalid_o, master_rdata_o,
    output slave_req_o, slave_addr_o, slave_we_o, slave_be_o, slave_wdata_o,
    input  slave_gnt_i, slave_rvalid_i, slave_rdata_i,
    output rsp_err_o
  );

  modport master (
    output master_sel_int_i, master_sel_vec_i, granted_master_i,
    output master_addr_i, master_we_i, master_be_i, master_wdata_i,
    input  master_gnt_o, master_rvalid_o, master_rdata_o,
    input  slave_req_o, slave_addr_o, slave_we_o, slave_be_o, slave_wdata_o,
    output slave_gnt_i, slave_rvalid_i, slave_rdata_i,
    input  rsp_err_o
  );
endinterface

// File: rtl/obi_interconnect_slave_port.sv
// Per-slave OBI port: zero-latency address-phase mux and grant return, in-order ID FIFO
// routing responses back to the issuing master; request is withheld while the FIFO is full.
module obi_interconnect_slave_port #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
  parameter int OUTSTANDING = 2
) (
  input logic                          clk_i,
  input logic                          rst_i,
  obi_interconnect_slave_port_if.slave bus
);
  localparam int PTR_W = (OUTSTANDING == 1) ? 1 : $clog2(OUTSTANDING);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [MASTER_BITS-1:0] id_fifo_q [OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   full;
  logic                   slave_req;
  logic                   accept;
  logic                   rsp_ok;
  logic [MASTER_BITS-1:0] rsp_id;

  assign full      = (count_q == CNT_W'(OUTSTANDING));
  assign slave_req = bus.granted_master_i & ~full & ~rst_i;
  assign accept    = slave_req & bus.slave_gnt_i;
  assign rsp_ok    = bus.slave_rvalid_i & (count_q != '0) & ~rst_i;
  assign rsp_id    = id_fifo_q[rd_ptr_q];

  assign bus.slave_req_o   = slave_req;
  assign bus.slave_addr_o  = bus.master_addr_i[bus.master_sel_int_i];
  assign bus.slave_we_o    = bus.master_we_i[bus.master_sel_int_i];
  assign bus.slave_be_o    = bus.master_be_i[bus.master_sel_int_i];
  assign bus.slave_wdata_o = bus.master_wdata_i[bus.master_sel_int_i];
  assign bus.master_gnt_o  = bus.master_sel_vec_i & {MASTERS{accept}};
  assign bus.rsp_err_o     = rsp_err_q;

  always_comb begin
    bus.master_rvalid_o = '0;
    bus.master_rdata_o  = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (rsp_ok && (rsp_id == MASTER_BITS'(m))) begin
        bus.master_rvalid_o[m] = 1'b1;
        bus.master_rdata_o[m]  = bus.slave_rdata_i;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rsp_err_d = rsp_err_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rsp_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (accept && !rsp_ok) begin
      count_d = count_q + 1'b1;
    end else if (!accept && rsp_ok) begin
      count_d = count_q - 1'b1;
    end
    // A response with nothing outstanding cannot belong to any master.
    if (bus.slave_rvalid_i && (count_q == '0)) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_fifo_q[wr_ptr_q] <= bus.master_sel_int_i;
    end
  end
endmodule

// File: tb/tb_obi_interconnect_slave_port.sv
// Directed bench with an in-order scoreboard of expected responding masters.
module tb_obi_interconnect_slave_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];

  obi_interconnect_slave_port_if #(.MASTERS(3), .MASTER_BITS(2)) bus ();

  obi_interconnect_slave_port #(.MASTERS(3), .MASTER_BITS(2), .OUTSTANDING(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int m);
    bus.master_sel_vec_i = 3'b001 << m;
    bus.master_sel_int_i = 2'(m);
    bus.granted_master_i = 1'b1;
    bus.slave_gnt_i      = 1'b1;
  endtask

  task automatic idle();
    bus.master_sel_vec_i = '0;
    bus.master_sel_int_i = '0;
    bus.granted_master_i = 1'b0;
    bus.slave_gnt_i      = 1'b0;
    bus.slave_rvalid_i   = 1'b0;
    bus.slave_rdata_i    = '0;
  endtask

  // Drive a slave response and compare against the head of the scoreboard.
  task automatic rsp(input logic [31:0] d);
    int m;
    bus.slave_rvalid_i = 1'b1;
    bus.slave_rdata_i  = d;
    #1;
    if (exp_q.size() == 0) begin
      check("rsp_sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      m = exp_q.pop_front();
      check("rsp_vld", 64'(bus.master_rvalid_o), 64'(3'b001 << m));
      for (int j = 0; j < 3; j++) begin
        check("rsp_dat", 64'(bus.master_rdata_o[j]), (j == m) ? 64'(d) : 64'd0);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      bus.master_addr_i[m]  = 32'h1000_0000 + 32'(4 * m);
      bus.master_be_i[m]    = 4'(1 << m);
      bus.master_wdata_i[m] = 32'hA000_0000 + 32'(m);
      bus.master_we_i[m]    = (m == 2);
    end
    idle();

    // Reset with every input active: outputs held low.
    sel(1);
    bus.slave_rvalid_i = 1'b1;
    #1;
    check("rst_req", 64'(bus.slave_req_o), 64'd0);
    check("rst_gnt", 64'(bus.master_gnt_o), 64'd0);
    check("rst_rvld", 64'(bus.master_rvalid_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_err", 64'(bus.rsp_err_o), 64'd0);
    check("rst_cnt", 64'(dut.count_q), 64'd0);

    // Single read from master 1.
    sel(1);
    #1;
    check("t1_req", 64'(bus.slave_req_o), 64'd1);
    check("t1_addr", 64'(bus.slave_addr_o), 64'h1000_0004);
    check("t1_gnt", 64'(bus.master_gnt_o), 64'b010);
    exp_q.push_back(1);
    tick();
    idle();
    #1;
    check("t1_cnt1", 64'(dut.count_q), 64'd1);
    check("t1_idle_rvld", 64'(bus.master_rvalid_o), 64'd0);
    tick();
    rsp(32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    check("t1_cnt0", 64'(dut.count_q), 64'd0);

    // Back-to-back masters 0 then 2.
    sel(0);
    #1;
    check("t2_gnt0", 64'(bus.master_gnt_o), 64'b001);
    check("t2_be0", 64'(bus.slave_be_o), 64'h1);
    exp_q.push_back(0);
    tick();
    sel(2);
    #1;
    check("t2_gnt2", 64'(bus.master_gnt_o), 64'b100);
    check("t2_we2", 64'(bus.slave_we_o), 64'd1);
    check("t2_wd2", 64'(bus.slave_wdata_o), 64'hA000_0002);
    exp_q.push_back(2);
    tick();
    idle();
    rsp(32'h0000_1111);
    tick();
    rsp(32'h0000_2222);
    tick();
    idle();

    // Full stall with master 1 held granted.
    sel(1);
    exp_q.push_back(1);
    tick();
    exp_q.push_back(1);
    tick();
    #1;
    check("t3_full_req", 64'(bus.slave_req_o), 64'd0);
    check("t3_full_gnt", 64'(bus.master_gnt_o), 64'd0);
    check("t3_full_cnt", 64'(dut.count_q), 64'd2);
    tick();
    rsp(32'h0000_3333);
    check("t3_pop_req", 64'(bus.slave_req_o), 64'd0);
    tick();
    bus.slave_rvalid_i = 1'b0;
    #1;
    check("t3_after_req", 64'(bus.slave_req_o), 64'd1);
    check("t3_after_gnt", 64'(bus.master_gnt_o), 64'b010);
    exp_q.push_back(1);
    tick();
    idle();
    rsp(32'h0000_4444);
    tick();
    rsp(32'h0000_5555);
    tick();
    idle();
    #1;
    check("t3_drain_cnt", 64'(dut.count_q), 64'd0);

    // Simultaneous accept and response at count 1.
    sel(0);
    exp_q.push_back(0);
    tick();
    sel(2);
    rsp(32'h0000_6666);
    check("t4_gnt", 64'(bus.master_gnt_o), 64'b100);
    exp_q.push_back(2);
    tick();
    idle();
    #1;
    check("t4_cnt", 64'(dut.count_q), 64'd1);
    rsp(32'h0000_7777);
    tick();
    idle();
    #1;
    check("t4_cnt0", 64'(dut.count_q), 64'd0);

    // Spurious response with nothing outstanding.
    bus.slave_rvalid_i = 1'b1;
    bus.slave_rdata_i  = 32'hBAD0_BAD0;
    #1;
    check("t5_rvld", 64'(bus.master_rvalid_o), 64'd0);
    check("t5_err_pre", 64'(bus.rsp_err_o), 64'd0);
    tick();
    idle();
    #1;
    check("t5_err_set", 64'(bus.rsp_err_o), 64'd1);
    check("t5_cnt", 64'(dut.count_q), 64'd0);
    tick();
    check("t5_err_sticky", 64'(bus.rsp_err_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_err_clr", 64'(bus.rsp_err_o), 64'd0);

    // Reset while two transactions are outstanding.
    sel(0);
    tick();
    sel(1);
    tick();
    #1;
    check("t6_cnt2", 64'(dut.count_q), 64'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_req", 64'(bus.slave_req_o), 64'd0);
    check("t6_rst_gnt", 64'(bus.master_gnt_o), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    exp_q.delete();
    #1;
    check("t6_cnt0", 64'(dut.count_q), 64'd0);
    bus.slave_rvalid_i = 1'b1;
    #1;
    check("t6_rvld", 64'(bus.master_rvalid_o), 64'd0);
    tick();
    idle();
    #1;
    check("t6_err", 64'(bus.rsp_err_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/obi_interconnect_slave_port.md
Name: obi_interconnect_slave_port

Overview:
- Per-slave port stage that consumes the master-selection result (integer index, one-hot vector, granted flag) for one slave.
- Muxes the winning master's OBI address phase onto the slave and returns the grant to that master only.
- Records the master index of every accepted transaction in an in-order ID FIFO, and routes each slave response (rvalid/rdata) back to the master that issued it.
- Sits between the master-select logic and one slave in the system-bus interconnect; one instance per slave.

Parameters:
- MASTERS, 3, number of bus masters.
- MASTER_BITS, (MASTERS==1 ? 1 : $clog2(MASTERS)), width of master index.
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (ID FIFO depth, >=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- master_sel_int_i  in  MASTER_BITS  index of selected master.
- master_sel_vec_i  in  MASTERS  one-hot selected master.
- granted_master_i  in  1  some master is selected for this slave.
- master_addr_i  in  32 x [MASTERS]  master addresses.
- master_we_i  in  1 x [MASTERS]  write enables.
- master_be_i  in  4 x [MASTERS]  byte enables.
- master_wdata_i  in  32 x [MASTERS]  write data.
- master_gnt_o  out  1 x [MASTERS]  grant to each master.
- master_rvalid_o  out  1 x [MASTERS]  response valid to each master.
- master_rdata_o  out  32 x [MASTERS]  read data to each master.
- slave_req_o  out  1  request to slave.
- slave_gnt_i  in  1  slave grant.
- slave_addr_o  out  32  muxed address.
- slave_we_o  out  1  muxed write enable.
- slave_be_o  out  4  muxed byte enables.
- slave_wdata_o  out  32  muxed write data.
- slave_rvalid_i  in  1  slave response valid.
- slave_rdata_i  in  32  slave read data.
- rsp_err_o  out  1  sticky protocol error (response with no outstanding ID).

Behaviour:
- State: ID FIFO of OUTSTANDING x MASTER_BITS entries; wr_ptr, rd_ptr and count (0..OUTSTANDING); rsp_err flag.
- Reset (rst_i=1):
  - count, wr_ptr, rd_ptr and rsp_err_o are cleared to 0 at the clock edge.
  - While rst_i is high, slave_req_o, all master_gnt_o and all master_rvalid_o are forced to 0.
  - Reset mid-operation discards all outstanding IDs; responses arriving after reset flag rsp_err_o.
- full = (count==OUTSTANDING).
- slave_req_o = granted_master_i & ~full & ~rst_i. Combinational, zero latency.
- Address-phase outputs (addr/we/be/wdata) are a combinational mux indexed by master_sel_int_i. When no master is granted they output master 0's values, which are don't-care.
- master_gnt_o[m] = master_sel_vec_i[m] & slave_gnt_i & slave_req_o. At most one grant is high.
- Accept event = slave_req_o & slave_gnt_i:
  - master_sel_int_i is written at wr_ptr.
  - wr_ptr increments, wrapping OUTSTANDING-1 -> 0.
- Response event = slave_rvalid_i & (count!=0):
  - master_rvalid_o[fifo[rd_ptr]] = 1 in the same cycle (combinational).
  - rd_ptr increments with wrap.
  - Responses are strictly in order.
- master_rdata_o[m] = slave_rdata_i when master_rvalid_o[m], else 0.
- count update on simultaneous accept and response: count unchanged, both pointers advance.
- Full: no bypass. A pop in the same cycle does not re-enable slave_req_o; the request waits one cycle.
- OBI rule: a response cannot arrive in the same cycle as the grant of its own transaction. slave_rvalid_i with count==0 is therefore a protocol error:
  - rsp_err_o is set to 1 and stays set until reset.
  - No master_rvalid_o is asserted and the pointers are unchanged.
- The master selection may change in any cycle without a grant. The block holds no address-phase state.

Test Plan:
- Single read, MASTERS=3. Master 1 selected (vec=3'b010, int=1), addr 0x1000_0004, slave_gnt_i=1 in cycle 0, rvalid with rdata 0xDEAD_BEEF in cycle 2 -> slave_addr_o=0x1000_0004 in cycle 0; master_gnt_o[1]=1; master_rvalid_o[1]=1 and master_rdata_o[1]=0xDEAD_BEEF in cycle 2; count returns to 0.
- Back-to-back: accept master 0 (cycle 0) then master 2 (cycle 1); responses in cycles 2 and 3 -> rvalid to master 0 in cycle 2, then master 2 in cycle 3; other rvalids stay 0.
- Full stall, OUTSTANDING=2: two accepts with no response, master 1 still granted -> slave_req_o=0 and master_gnt_o=0. Response arrives in cycle N -> slave_req_o stays 0 in cycle N and rises in cycle N+1.
- Simultaneous accept and response at count=1 -> count stays 1, responding ID is the old head, new ID is queued.
- Spurious rvalid at count=0 -> rsp_err_o=1 next cycle and stays 1; all master_rvalid_o=0; rst_i clears it.
- Reset mid-operation: count=2, assert rst_i one cycle -> count=0; slave_req_o=0 during reset; a later rvalid sets rsp_err_o.
